// File: rtl/prover_shim_negate_multi.sv
// Negate shim: m[c][i] = (1 - z[c][i]) mod q over nCh channels of nElems elements,
// time-multiplexed over nUnits field_one_minus units with per-channel masking and done flags.

module field_one_minus #(
  parameter int          F_NBITS = 16,
  parameter int unsigned Q       = 65521,
  parameter int          LAT     = 2
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  output logic [F_NBITS-1:0] y,
  output logic               ready
);
  localparam int CW = $clog2(LAT + 1);
  localparam logic [F_NBITS-1:0] QV = F_NBITS'(Q);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [F_NBITS-1:0] y_q, y_d;
  logic [F_NBITS:0]   diff;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    y_d   = y_q;
    diff  = {1'b0, QV} + (F_NBITS+1)'(1) - {1'b0, a};
    if (en) begin
      cnt_d = CW'(LAT);
      // 0 and 1 map below q directly; everything else wraps to q+1-a.
      if (a == '0)                 y_d = F_NBITS'(1);
      else if (a == F_NBITS'(1))   y_d = '0;
      else                         y_d = diff[F_NBITS-1:0];
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      y_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

  assign y     = y_q;
  assign ready = (cnt_q == '0);
endmodule

module prover_shim_negate_multi #(
  parameter int          nCh     = 3,
  parameter int          nElems  = 4,
  parameter int          nUnits  = 2,
  parameter int          F_NBITS = 16,
  parameter int unsigned Q       = 65521,
  parameter int          UNIT_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            en,
  input  logic [nCh-1:0]                  ch_mask,
  input  logic [F_NBITS*nCh*nElems-1:0]   z,
  output logic [F_NBITS*nCh*nElems-1:0]   m_p1,
  output logic [nCh-1:0]                  ch_done,
  output logic                            ready
);
  localparam int NB   = (nElems + nUnits - 1) / nUnits;
  localparam int NE   = nCh * nElems;
  localparam int CH_W = (nCh > 1) ? $clog2(nCh) : 1;
  localparam int B_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic               en_dly_q;
  logic [nCh-1:0]     mask_q, mask_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [nCh-1:0]     ch_done_q, ch_done_d;
  logic [F_NBITS-1:0] m_q [NE];
  logic [F_NBITS-1:0] m_d [NE];

  logic               start;
  logic               all_ready;
  logic [CH_W:0]      nxt;
  logic [nUnits-1:0]  issued, unit_en, unit_rdy;
  logic [F_NBITS-1:0] unit_a [nUnits];
  logic [F_NBITS-1:0] unit_y [nUnits];

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input logic [nCh-1:0] mask, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int c = nCh - 1; c >= 0; c--) begin
      if (c >= from && mask[c]) r = {1'b1, CH_W'(c)};
    end
    return r;
  endfunction

  assign start = en & ~en_dly_q;
  assign ready = (state_q == S_IDLE) & ~start;

  always_comb begin
    issued  = '0;
    unit_en = '0;
    for (int u = 0; u < nUnits; u++) begin
      unit_a[u] = '0;
      issued[u] = (int'(b_q) * nUnits + u) < nElems;
      if (state_q == S_ISSUE && issued[u]) begin
        unit_en[u] = 1'b1;
        unit_a[u]  = z[(int'(ch_q) * nElems + int'(b_q) * nUnits + u) * F_NBITS +: F_NBITS];
      end
    end
  end

  assign all_ready = &(unit_rdy | ~issued);

  for (genvar u = 0; u < nUnits; u++) begin : g_unit
    field_one_minus #(.F_NBITS(F_NBITS), .Q(Q), .LAT(UNIT_LAT)) u_fom (
      .clk   (clk),
      .rstb  (rstb),
      .en    (unit_en[u]),
      .a     (unit_a[u]),
      .y     (unit_y[u]),
      .ready (unit_rdy[u])
    );
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    b_d       = b_q;
    ch_done_d = ch_done_q;
    m_d       = m_q;
    nxt       = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_done_d = ~ch_mask;
          mask_d    = ch_mask;
          nxt       = find_ch(ch_mask, 0);
          if (nxt[CH_W]) begin
            state_d = S_ISSUE;
            ch_d    = nxt[CH_W-1:0];
            b_d     = '0;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (all_ready) begin
          for (int u = 0; u < nUnits; u++) begin
            if (issued[u]) m_d[int'(ch_q) * nElems + int'(b_q) * nUnits + u] = unit_y[u];
          end
          if (int'(b_q) == NB - 1) begin
            ch_done_d[ch_q] = 1'b1;
            nxt = find_ch(mask_q, int'(ch_q) + 1);
            if (nxt[CH_W]) begin
              state_d = S_ISSUE;
              ch_d    = nxt[CH_W-1:0];
              b_d     = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            b_d     = b_q + B_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the result array is reset because a reset must leave no partial results visible.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      en_dly_q  <= 1'b1;
      mask_q    <= '0;
      ch_q      <= '0;
      b_q       <= '0;
      ch_done_q <= '0;
      for (int i = 0; i < NE; i++) m_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      en_dly_q  <= en;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      b_q       <= b_d;
      ch_done_q <= ch_done_d;
      m_q       <= m_d;
    end
  end

  for (genvar i = 0; i < NE; i++) begin : g_out
    assign m_p1[i*F_NBITS +: F_NBITS] = m_q[i];
  end

  assign ch_done = ch_done_q;
endmodule

// File: tb/tb_prover_shim_negate_multi.sv
// Randomised bench for prover_shim_negate_multi against a plain modular-arithmetic model,
// plus a second instance with a partial last batch.

module tb_prover_shim_negate_multi;
  localparam int          F   = 16;
  localparam int unsigned Q   = 65521;
  localparam int          NCH = 3;
  localparam int          NE  = 4;
  localparam int          NE5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rstb, en, en_b;
  logic [NCH-1:0]         ch_mask, mask_b, ch_done, done_b;
  logic [F*NCH*NE-1:0]    z, m_p1;
  logic [F*NCH*NE5-1:0]   z_b, m_b;
  logic                   ready, ready_b;

  prover_shim_negate_multi #(.nCh(NCH), .nElems(NE), .nUnits(2), .F_NBITS(F), .Q(Q)) dut (
    .clk(clk), .rstb(rstb), .en(en), .ch_mask(ch_mask), .z(z),
    .m_p1(m_p1), .ch_done(ch_done), .ready(ready)
  );

  prover_shim_negate_multi #(.nCh(NCH), .nElems(NE5), .nUnits(2), .F_NBITS(F), .Q(Q)) dut_b (
    .clk(clk), .rstb(rstb), .en(en_b), .ch_mask(mask_b), .z(z_b),
    .m_p1(m_b), .ch_done(done_b), .ready(ready_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: target values after the current run, and values before it.
  int unsigned zv     [NCH][NE];
  int unsigned exp_m  [NCH][NE];
  int unsigned prev_m [NCH][NE];
  logic [NCH-1:0] run_mask  = '0;
  logic [NCH-1:0] last_done = '0;
  bit             chk_on    = 1'b0;
  int             en_cnt_a  = 0;
  int             en_cnt_b  = 0;

  function automatic int unsigned one_minus(input int unsigned v);
    return (Q + 1 - v) % Q;
  endfunction

  function automatic int unsigned get_m(input int c, input int i);
    return int'(m_p1[(c*NE+i)*F +: F]);
  endfunction

  always @(posedge clk) begin
    en_cnt_a += $countones(dut.unit_en);
    en_cnt_b += $countones(dut_b.unit_en);
  end

  // Every cycle of a run: entries are old or final, done channels are final,
  // done bits only rise and in ascending channel order, ready only once all are done.
  bit ok_cyc;
  always @(negedge clk) begin
    if (chk_on) begin
      ok_cyc = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NE; i++) begin
          if (get_m(c, i) != exp_m[c][i] && get_m(c, i) != prev_m[c][i]) ok_cyc = 1'b0;
          if (ch_done[c] && get_m(c, i) != exp_m[c][i]) ok_cyc = 1'b0;
        end
        if (run_mask[c] && ch_done[c])
          for (int c2 = 0; c2 < c; c2++)
            if (run_mask[c2] && !ch_done[c2]) ok_cyc = 1'b0;
      end
      if ((last_done & ~ch_done) != '0) ok_cyc = 1'b0;
      if (ready != (ch_done == '1)) ok_cyc = 1'b0;
      last_done = ch_done;
      check("cycle_consistency", ok_cyc, 1'b1);
    end
  end

  task automatic load_z();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++)
        z[(c*NE+i)*F +: F] = F'(zv[c][i]);
  endtask

  task automatic run_a(input logic [NCH-1:0] mask, input bit glitch);
    logic [NCH-1:0] exp_done;
    int cycles, base;
    bit ok;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) begin
        prev_m[c][i] = exp_m[c][i];
        if (mask[c]) exp_m[c][i] = one_minus(zv[c][i]);
      end
    load_z();
    ch_mask  = mask;
    run_mask = mask;
    base     = en_cnt_a;
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    exp_done = ~mask;
    check("done_after_start", ch_done, exp_done);
    last_done = ch_done;
    chk_on    = 1'b1;
    cycles    = 0;
    while (!ready && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (glitch && cycles == 5) en = 1'b1;
      if (glitch && cycles == 6) en = 1'b0;
    end
    check("run_timeout", cycles < 200, 1'b1);
    @(negedge clk); #1;
    chk_on = 1'b0;
    check("final_done", ch_done, {NCH{1'b1}});
    check("unit_enables", en_cnt_a - base, $countones(mask) * NE);
    ok = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++)
        if (get_m(c, i) != exp_m[c][i]) ok = 1'b0;
    check("final_results", ok, 1'b1);
  endtask

  initial begin
    bit ok;
    int cycles, base;
    int unsigned zb [NCH][NE5];

    rstb = 1'b0; en = 1'b1; en_b = 1'b0;
    ch_mask = '0; mask_b = '0; z = '0; z_b = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) begin
        exp_m[c][i] = 0; prev_m[c][i] = 0; zv[c][i] = 0;
      end
    #12;
    @(negedge clk); rstb = 1'b1;

    // en held high through and after reset must not start a run.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("reset_ready", ready, 1'b1);
      check("reset_done", ch_done, 3'b000);
      check("reset_m_zero", m_p1 == '0, 1'b1);
    end
    check("reset_no_enables", en_cnt_a, 0);
    en = 1'b0;
    @(negedge clk);

    // Directed run with hand-computed literal pins.
    zv[0] = '{0, 1, 2, 5};
    zv[1] = '{Q-1, 3, 0, 1};
    zv[2] = '{7, 7, 7, 7};
    run_a(3'b111, 1'b0);
    check("m00_lit", get_m(0, 0), 1);
    check("m01_lit", get_m(0, 1), 0);
    check("m02_lit", get_m(0, 2), 65520);
    check("m03_lit", get_m(0, 3), 65517);
    check("m10_lit", get_m(1, 0), 2);
    check("m11_lit", get_m(1, 1), 65519);
    check("m13_lit", get_m(1, 3), 0);
    check("m22_lit", get_m(2, 2), 65515);

    // Single-channel rerun leaves other channels untouched.
    zv[0] = '{9, 9, 9, 9};
    zv[1] = '{4, 4, 4, 4};
    run_a(3'b010, 1'b0);
    check("m12_lit", get_m(1, 2), 65518);
    check("m00_kept", get_m(0, 0), 1);
    check("m23_kept", get_m(2, 3), 65515);

    // Start edge while busy is ignored.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) zv[c][i] = $urandom_range(0, Q-1);
    run_a(3'b111, 1'b1);

    // Empty mask: immediate done, nothing issued.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) zv[c][i] = $urandom_range(0, Q-1);
    run_a(3'b000, 1'b0);

    // Random runs.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NE; i++)
          zv[c][i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, Q-1);
      run_a(NCH'($urandom_range(0, 7)), r[0]);
    end

    // Reset in the middle of a run.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) zv[c][i] = $urandom_range(2, Q-1);
    load_z();
    ch_mask = 3'b111;
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    repeat (6) @(posedge clk);
    #1 rstb = 1'b0;
    #2;
    check("midreset_m_zero", m_p1 == '0, 1'b1);
    check("midreset_done", ch_done, 3'b000);
    check("midreset_ready", ready, 1'b1);
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE; i++) exp_m[c][i] = 0;
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    run_a(3'b101, 1'b0);

    // Partial last batch: five elements over two units.
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE5; i++) begin
        zb[c][i] = $urandom_range(0, Q-1);
        z_b[(c*NE5+i)*F +: F] = F'(zb[c][i]);
      end
    mask_b = 3'b111;
    base   = en_cnt_b;
    @(negedge clk); en_b = 1'b1;
    @(posedge clk); #1; en_b = 1'b0;
    cycles = 0;
    while (!ready_b && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("b_timeout", cycles < 300, 1'b1);
    check("b_done", done_b, 3'b111);
    check("b_unit_enables", en_cnt_b - base, NCH * NE5);
    ok = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NE5; i++)
        if (int'(m_b[(c*NE5+i)*F +: F]) != one_minus(zb[c][i])) ok = 1'b0;
    check("b_results", ok, 1'b1);
    for (int c = 0; c < NCH; c++)
      check("b_elem4", m_b[(c*NE5+4)*F +: F], one_minus(zb[c][4]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/prover_shim_negate_multi.md
Name: prover_shim_negate_multi

Overview:
- Generalised negate shim for the sumcheck prover front end.
- Computes m[c][i] = (1 - z[c][i]) mod q for nCh input vectors of nElems field elements each, using nUnits field_one_minus instances in time-multiplexed batches.
- Per-channel mask skips channels; per-channel done flags let downstream chi/beta builders start early, channel by channel.
- Sits between the output-layer prover controller and the chi/beta computation blocks.

Parameters:
- nCh, 3, number of input vectors (channels), >=1
- nElems, 4, elements per channel, >=1
- nUnits, 2, parallel field_one_minus instances, 1..nElems

Ports:
- clk  input  1  clock
- rstb  input  1  reset, asynchronous, active-low
- en  input  1  start request; rising edge starts a run
- ch_mask  input  nCh  1 = process channel c; sampled on start
- z  input  F_NBITS x (nCh*nElems)  element [c*nElems+i] = z[c][i]; must be held stable until ready
- m_p1  output  F_NBITS x (nCh*nElems)  registered results, same indexing
- ch_done  output  nCh  channel c results valid for the current run
- ready  output  1  idle and no start this cycle

Behaviour:
- Reset: state IDLE; en_dly=1, so en held high through reset does not start; all m_p1=0; ch_done=0; ready=1.
- Start handshake:
  - start = en & ~en_dly.
  - ready = (state==IDLE) & ~start.
  - Start is accepted only in IDLE. Edges while busy are ignored and are not queued.
- On the start cycle:
  - ch_done <= ~ch_mask_sampled. Masked channels report done immediately and keep their previous m_p1 values.
  - Channel counter c <= first set bit of ch_mask; batch index b <= 0.
  - If ch_mask==0, stay IDLE. ready reasserts the next cycle.
- States:
  - IDLE
  - ISSUE: one cycle. Pulse en on units u with b*nUnits+u < nElems, input z[c][b*nUnits+u].
  - WAIT: hold until every issued unit has ready=1. Units not issued count as ready.
- WAIT exit:
  - Write each issued unit's result into m_p1[c][b*nUnits+u] in the same cycle.
  - If b is the last batch (ceil(nElems/nUnits)-1): set ch_done[c]. Go to ISSUE on the next set mask bit with b=0, or to IDLE if none remain.
  - Otherwise b <= b+1 and go to ISSUE.
- Last batch may be partial: unused units get en=0 and input 0. Their outputs are never written.
- Arithmetic: result is in [0,q-1] for every input in [0,q-1]. z=0 -> 1; z=1 -> 0. Inputs >= q are out of contract.
- Timing:
  - Per-batch latency = 1 + unit latency + 1.
  - Channel done is visible in the cycle after its final WAIT exit.
  - Total runtime scales with popcount(ch_mask)*ceil(nElems/nUnits).
- Reset mid-run: everything returns to reset values immediately (async). No partial results survive.
- ch_done bits stay set after the run and clear only on the next accepted start or on reset.
- m_p1 entries change only on their own writeback cycle.

Test Plan:
- Reset with en=1, then hold en=1 -> ready stays 1, no run starts, m_p1 all 0.
- Defaults, ch_mask=3'b111, z[0]={0,1,2,5}, z[1]={q-1,3,0,1}, z[2] all 7:
  - m_p1[0]={1,0,q-1,q-4}, m_p1[1]={2,q-2,1,0}, m_p1[2] all q-6.
  - ch_done rises in order 001 -> 011 -> 111.
  - ready returns 1 once after the last done.
- Rerun with ch_mask=3'b010 and new z[1]={4,4,4,4}:
  - ch_done=101 on the cycle after start.
  - m_p1[1] becomes all q-3; m_p1[0] and m_p1[2] unchanged from the previous run.
- nElems=5, nUnits=2 (partial last batch) -> 3 batches per channel; element 4 correct; unit 1 never enabled in batch 2.
- Second en rising edge during WAIT -> ignored; run completes once with correct results.
- ch_mask=0 start -> ch_done=111 next cycle, no unit enable pulses, m_p1 unchanged.
- rstb low mid-run -> m_p1=0, ch_done=0, ready=1.
